instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/instr_fetch_mem.sv | 33 +++
 rtl/instr_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, opcode field and FSM encoding.
package instr_fetch_pkg;

  localparam int unsigned FETCH_INSTR_W = 37;
  localparam int unsigned FETCH_ADDR_W  = 8;

  localparam int unsigned OP_LSB = 17;
  localparam int unsigned OP_MSB = 20;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

  localparam logic [OP_W-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_halt_op(input logic [OP_W-1:0] op);
    return op == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// Program storage: one write port, one synchronous read port with enable.
// Only the read register is reset; array contents survive reset.
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = FETCH_INSTR_W,
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address write lands after this read samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC with stall, jump redirect and HALT detection.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = FETCH_INSTR_W,
  parameter int unsigned ADDR_W  = FETCH_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] instr_pc_n;
  logic              valid_n;
  logic              halted_n;
  logic              mem_re;
  logic              cur_halt;

  // The presented word is live and carries the HALT opcode.
  assign cur_halt = instr_valid && is_halt_op(instr[OP_MSB:OP_LSB]);

  instr_mem #(
    .DATA_W (INSTR_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (jump_en || start) state_n = ST_RUN;
      ST_RUN:  if (!jump_en && !stall && cur_halt) state_n = ST_HALT;
      ST_HALT: if (jump_en) state_n = ST_RUN;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath next values; a HALT word is retired before any further fetch.
  always_comb begin
    pc_n       = pc;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    halted_n   = 1'b0;
    mem_re     = 1'b0;
    case (state)
      ST_IDLE: begin
        valid_n = 1'b0;
        if (jump_en)    pc_n = jump_addr;
        else if (start) pc_n = '0;
      end
      ST_RUN: begin
        if (jump_en) begin
          valid_n = 1'b0;
          pc_n    = jump_addr;
        end else if (!stall) begin
          if (cur_halt) begin
            valid_n  = 1'b0;
            halted_n = 1'b1;
          end else begin
            mem_re     = 1'b1;
            instr_pc_n = pc;
            valid_n    = 1'b1;
            pc_n       = pc + ADDR_W'(1);
          end
        end
      end
      ST_HALT: begin
        valid_n = 1'b0;
        if (jump_en) pc_n = jump_addr;
        else         halted_n = 1'b1;
      end
      default: begin
        valid_n = 1'b0;
      end
    endcase
  end

endmodule
